// File: rtl/bsg_manycore_remote_req_initiator.sv
// Remote load/store initiator: issues request packets under a credit limit, tracks pending
// load destinations and buffers returned load data in a 2-entry FIFO for writeback.
module bsg_manycore_remote_req_initiator #(
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int reg_id_width_p    = 5,
    parameter int max_out_credits_p = 32
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,

    input  logic                                     req_v_i,
    input  logic                                     req_we_i,
    input  logic [addr_width_p-1:0]                  req_addr_i,
    input  logic [data_width_p-1:0]                  req_data_i,
    input  logic [(data_width_p>>3)-1:0]             req_mask_i,
    input  logic [x_cord_width_p-1:0]                req_x_i,
    input  logic [y_cord_width_p-1:0]                req_y_i,
    input  logic [reg_id_width_p-1:0]                req_reg_id_i,
    output logic                                     req_ready_o,

    output logic                                     pkt_v_o,
    output logic                                     pkt_we_o,
    output logic [addr_width_p-1:0]                  pkt_addr_o,
    output logic [data_width_p-1:0]                  pkt_data_o,
    output logic [(data_width_p>>3)-1:0]             pkt_mask_o,
    output logic [x_cord_width_p-1:0]                pkt_x_o,
    output logic [y_cord_width_p-1:0]                pkt_y_o,
    output logic [reg_id_width_p-1:0]                pkt_reg_id_o,
    input  logic                                     pkt_ready_i,

    input  logic                                     rsp_v_i,
    input  logic                                     rsp_is_load_i,
    input  logic [data_width_p-1:0]                  rsp_data_i,
    input  logic [reg_id_width_p-1:0]                rsp_reg_id_i,
    output logic                                     rsp_yumi_o,

    output logic                                     load_resp_v_o,
    output logic [data_width_p-1:0]                  load_resp_data_o,
    output logic [reg_id_width_p-1:0]                load_resp_rd_o,
    input  logic                                     load_resp_yumi_i,

    output logic [$clog2(max_out_credits_p+1)-1:0]   credits_used_o,
    output logic                                     idle_o,
    output logic                                     error_o
);

    localparam int MASK_W   = data_width_p >> 3;
    localparam int CREDIT_W = $clog2(max_out_credits_p + 1);
    localparam int NUM_REGS = 1 << reg_id_width_p;

    logic                      pkt_v_q, pkt_v_d;
    logic                      pkt_we_q, pkt_we_d;
    logic [addr_width_p-1:0]   pkt_addr_q, pkt_addr_d;
    logic [data_width_p-1:0]   pkt_data_q, pkt_data_d;
    logic [MASK_W-1:0]         pkt_mask_q, pkt_mask_d;
    logic [x_cord_width_p-1:0] pkt_x_q, pkt_x_d;
    logic [y_cord_width_p-1:0] pkt_y_q, pkt_y_d;
    logic [reg_id_width_p-1:0] pkt_reg_id_q, pkt_reg_id_d;

    logic [CREDIT_W-1:0]       credits_q, credits_d;
    logic [NUM_REGS-1:0]       pending_q, pending_d;
    logic                      error_q, error_d;

    logic [data_width_p-1:0]   fifo_data_q [2];
    logic [data_width_p-1:0]   fifo_data_d [2];
    logic [reg_id_width_p-1:0] fifo_rd_q [2];
    logic [reg_id_width_p-1:0] fifo_rd_d [2];
    logic                      wptr_q, wptr_d;
    logic                      rptr_q, rptr_d;
    logic [1:0]                count_q, count_d;

    logic fifo_empty, fifo_full;
    logic accept, load_enq, load_deq, rsp_take;

    always_comb begin
        fifo_empty = (count_q == 2'd0);
        fifo_full  = (count_q == 2'd2);

        // Outputs with combinational paths are forced low while reset is held.
        req_ready_o = reset_n_i
                    & (credits_q < CREDIT_W'(max_out_credits_p))
                    & (~pkt_v_q | pkt_ready_i)
                    & (req_we_i | ~pending_q[req_reg_id_i]);
        accept      = req_v_i & req_ready_o;

        load_deq    = load_resp_yumi_i & ~fifo_empty;
        rsp_yumi_o  = reset_n_i & rsp_v_i & (~rsp_is_load_i | ~fifo_full | load_deq);
        rsp_take    = rsp_yumi_o;
        load_enq    = rsp_take & rsp_is_load_i;

        pkt_v_d      = pkt_v_q;
        pkt_we_d     = pkt_we_q;
        pkt_addr_d   = pkt_addr_q;
        pkt_data_d   = pkt_data_q;
        pkt_mask_d   = pkt_mask_q;
        pkt_x_d      = pkt_x_q;
        pkt_y_d      = pkt_y_q;
        pkt_reg_id_d = pkt_reg_id_q;
        credits_d    = credits_q;
        pending_d    = pending_q;
        error_d      = error_q;
        fifo_data_d  = fifo_data_q;
        fifo_rd_d    = fifo_rd_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;

        if (accept) begin
            pkt_v_d      = 1'b1;
            pkt_we_d     = req_we_i;
            pkt_addr_d   = req_addr_i;
            pkt_data_d   = req_data_i;
            pkt_mask_d   = req_mask_i;
            pkt_x_d      = req_x_i;
            pkt_y_d      = req_y_i;
            pkt_reg_id_d = req_reg_id_i;
        end else if (pkt_ready_i) begin
            pkt_v_d = 1'b0;
        end

        // A response at zero credits is an error and must not wrap the counter.
        if (rsp_take && credits_q == '0) begin
            error_d = 1'b1;
        end
        if (accept && !(rsp_take && credits_q != '0)) begin
            credits_d = credits_q + CREDIT_W'(1);
        end else if (!accept && rsp_take && credits_q != '0) begin
            credits_d = credits_q - CREDIT_W'(1);
        end

        if (load_enq && !pending_q[rsp_reg_id_i]) begin
            error_d = 1'b1;
        end

        // Pending clears on dequeue, so a same-register load waits for writeback.
        if (load_deq) begin
            pending_d[fifo_rd_q[rptr_q]] = 1'b0;
            rptr_d = ~rptr_q;
        end
        if (accept && !req_we_i) begin
            pending_d[req_reg_id_i] = 1'b1;
        end

        if (load_enq) begin
            fifo_data_d[wptr_q] = rsp_data_i;
            fifo_rd_d[wptr_q]   = rsp_reg_id_i;
            wptr_d = ~wptr_q;
        end
        count_d = count_q + 2'(load_enq) - 2'(load_deq);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pkt_v_q      <= 1'b0;
            pkt_we_q     <= 1'b0;
            pkt_addr_q   <= '0;
            pkt_data_q   <= '0;
            pkt_mask_q   <= '0;
            pkt_x_q      <= '0;
            pkt_y_q      <= '0;
            pkt_reg_id_q <= '0;
            credits_q    <= '0;
            pending_q    <= '0;
            error_q      <= 1'b0;
            wptr_q       <= 1'b0;
            rptr_q       <= 1'b0;
            count_q      <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_rd_q[i]   <= '0;
            end
        end else begin
            pkt_v_q      <= pkt_v_d;
            pkt_we_q     <= pkt_we_d;
            pkt_addr_q   <= pkt_addr_d;
            pkt_data_q   <= pkt_data_d;
            pkt_mask_q   <= pkt_mask_d;
            pkt_x_q      <= pkt_x_d;
            pkt_y_q      <= pkt_y_d;
            pkt_reg_id_q <= pkt_reg_id_d;
            credits_q    <= credits_d;
            pending_q    <= pending_d;
            error_q      <= error_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_rd_q[i]   <= fifo_rd_d[i];
            end
        end
    end

    always_comb begin
        pkt_v_o          = pkt_v_q;
        pkt_we_o         = pkt_we_q;
        pkt_addr_o       = pkt_addr_q;
        pkt_data_o       = pkt_data_q;
        pkt_mask_o       = pkt_mask_q;
        pkt_x_o          = pkt_x_q;
        pkt_y_o          = pkt_y_q;
        pkt_reg_id_o     = pkt_reg_id_q;
        load_resp_v_o    = ~fifo_empty;
        load_resp_data_o = fifo_data_q[rptr_q];
        load_resp_rd_o   = fifo_rd_q[rptr_q];
        credits_used_o   = credits_q;
        error_o          = error_q;
        idle_o           = reset_n_i & (credits_q == '0) & ~pkt_v_q & fifo_empty;
    end

endmodule
